// File: rtl/generic_spi_pkg.sv
// Shared types and encodings for the generic SPI controller.
package generic_spi_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Bit positions inside spi_mode = {CPOL, CPHA}
  localparam int unsigned CPOL_BIT = 1;
  localparam int unsigned CPHA_BIT = 0;

  // Two-bit state field reported on status[1:0]
  localparam logic [1:0] STAT_IDLE   = 2'd0;
  localparam logic [1:0] STAT_ACTIVE = 2'd1;
  localparam logic [1:0] STAT_DONE   = 2'd2;

  // Map an FSM state onto the reported status field
  function automatic logic [1:0] status_code(input state_e s);
    case (s)
      ST_SETUP, ST_SHIFT, ST_HOLD: status_code = STAT_ACTIVE;
      ST_DONE:                     status_code = STAT_DONE;
      default:                     status_code = STAT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter producing sclk and its leading/trailing edge ticks.
// Outputs ending in _c_o are combinational ticks valid in the cycle before
// the corresponding sclk edge becomes visible.
module spi_clk_gen #(
  parameter int unsigned CLKDIV_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                toggle_i,
  input  logic                cpol_i,
  input  logic [CLKDIV_W-1:0] div_i,
  output logic                half_c_o,
  output logic                lead_c_o,
  output logic                trail_c_o,
  output logic                sclk_o
);

  logic [CLKDIV_W-1:0] cnt_q, cnt_d;
  logic                sclk_q, sclk_d;

  // Half-period end detection, edge classification and next-state logic
  always_comb begin
    half_c_o  = en_i && (cnt_q == div_i);
    lead_c_o  = half_c_o && toggle_i && (sclk_q == cpol_i);
    trail_c_o = half_c_o && toggle_i && (sclk_q != cpol_i);
    cnt_d     = cnt_q;
    sclk_d    = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = cpol_i;
    end else begin
      cnt_d = half_c_o ? '0 : cnt_q + CLKDIV_W'(1);
      if (half_c_o && toggle_i) begin
        sclk_d = ~sclk_q;
      end
    end
  end

  // Counter and sclk registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/generic_spi_controller_mc.sv
// Single-clock SPI controller: shifts a bit-addressed write memory out on pico
// and captures poci into a read memory, all four SPI modes, N chip selects.
// Optional feature: define SPI_LOOPBACK_EN to add the loopback input, which
// samples the internal pico register instead of poci.
module generic_spi_controller_mc
  import generic_spi_pkg::*;
#(
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned MEM_DEPTH = 64,
  parameter  int unsigned NUM_CS    = 4,
  parameter  int unsigned CLKDIV_W  = 16,
  localparam int unsigned AW        = $clog2(MEM_DEPTH),
  localparam int unsigned CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                axi_clk,
  input  logic                axi_reset,
  output logic                sclk,
  output logic                pico,
  input  logic                poci,
  output logic [NUM_CS-1:0]   cs_b,
`ifdef SPI_LOOPBACK_EN
  input  logic                loopback,
`endif
  input  logic [DATA_W-1:0]   mem_write,
  input  logic                mem_write_strb,
  output logic [AW-1:0]       mem_write_ptr,
  input  logic                mem_write_ptr_reset,
  output logic [DATA_W-1:0]   mem_read,
  input  logic                mem_read_strb,
  output logic [AW-1:0]       mem_read_ptr,
  input  logic                mem_read_ptr_reset,
  input  logic [31:0]         spi_len,
  input  logic [CSW-1:0]      spi_cs_sel,
  input  logic [1:0]          spi_mode,
  input  logic [CLKDIV_W-1:0] clk_div,
  input  logic                spi_strb,
  output logic                busy,
  output logic                done,
  output logic [31:0]         transaction_count,
  output logic [2:0]          status
);

  localparam int unsigned BW       = $clog2(DATA_W);
  localparam int unsigned MAX_BITS = MEM_DEPTH * DATA_W;
  localparam int unsigned BIT_W    = $clog2(MAX_BITS) + 1;

  logic [DATA_W-1:0] wmem [MEM_DEPTH];
  logic [DATA_W-1:0] rmem [MEM_DEPTH];

  state_e              state_q, state_d;
  logic [BIT_W-1:0]    len_q, len_d;
  logic [1:0]          mode_q, mode_d;
  logic [CLKDIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
  logic                phase_q, phase_d;
  logic                pico_q, pico_d;
  logic [NUM_CS-1:0]   cs_b_q, cs_b_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         count_q, count_d;
  logic [2:0]          status_q, status_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;

  logic              accept_c, last_c, sample_bit_c, cpol_c;
  logic              en_c, toggle_c, half_c, lead_c, trail_c;
  logic [BIT_W-1:0]  nxt_idx_c;
  logic [AW-1:0]     cur_word_c, nxt_word_c;
  logic [BW-1:0]     cur_bit_c, nxt_bit_c;
  logic [DATA_W-1:0] wword0_c, wword_cur_c, wword_nxt_c;
  logic              wbit0_c, wbit_cur_c, wbit_nxt_c;
  logic              rmem_we_c, rmem_val_c;
  logic [AW-1:0]     rmem_word_c;
  logic [BW-1:0]     rmem_bit_c;

  // Start condition, bit addressing and write-memory lookups for drive points
  assign accept_c     = (state_q == ST_IDLE) && spi_strb && (spi_len != 32'd0);
  assign last_c       = (bit_idx_q == len_q - BIT_W'(1));
  assign nxt_idx_c    = bit_idx_q + BIT_W'(1);
  assign cur_word_c   = bit_idx_q[BIT_W-2:BW];
  assign cur_bit_c    = bit_idx_q[BW-1:0];
  assign nxt_word_c   = nxt_idx_c[BIT_W-2:BW];
  assign nxt_bit_c    = nxt_idx_c[BW-1:0];
  assign wword0_c     = wmem[AW'(0)];
  assign wword_cur_c  = wmem[cur_word_c];
  assign wword_nxt_c  = wmem[nxt_word_c];
  assign wbit0_c      = wword0_c[0];
  assign wbit_cur_c   = wword_cur_c[cur_bit_c];
  assign wbit_nxt_c   = wword_nxt_c[nxt_bit_c];

`ifdef SPI_LOOPBACK_EN
  assign sample_bit_c = loopback ? pico_q : poci;
`else
  assign sample_bit_c = poci;
`endif

  // Clock generator runs only while chip select is active; sclk is preloaded
  // with the new CPOL on the accepting edge so SETUP already shows idle level.
  assign en_c     = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  assign toggle_c = (state_q == ST_SETUP) ||
                    ((state_q == ST_SHIFT) && !(phase_q && last_c));
  assign cpol_c   = accept_c ? spi_mode[CPOL_BIT] : mode_q[CPOL_BIT];

  spi_clk_gen #(
    .CLKDIV_W (CLKDIV_W)
  ) u_clk_gen (
    .clk_i     (axi_clk),
    .rst_i     (axi_reset),
    .en_i      (en_c),
    .toggle_i  (toggle_c),
    .cpol_i    (cpol_c),
    .div_i     (div_q),
    .half_c_o  (half_c),
    .lead_c_o  (lead_c),
    .trail_c_o (trail_c),
    .sclk_o    (sclk)
  );

  // Transaction FSM: next state, shift datapath and read-memory capture
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    mode_d      = mode_q;
    div_d       = div_q;
    bit_idx_d   = bit_idx_q;
    phase_d     = phase_q;
    pico_d      = pico_q;
    cs_b_d      = cs_b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    count_d     = count_q;
    rmem_we_c   = 1'b0;
    rmem_word_c = cur_word_c;
    rmem_bit_c  = cur_bit_c;
    rmem_val_c  = sample_bit_c;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d   = ST_SETUP;
          len_d     = (spi_len > 32'(MAX_BITS)) ? BIT_W'(MAX_BITS) : BIT_W'(spi_len);
          mode_d    = spi_mode;
          div_d     = clk_div;
          bit_idx_d = '0;
          phase_d   = 1'b0;
          pico_d    = spi_mode[CPHA_BIT] ? 1'b0 : wbit0_c;
          cs_b_d    = ~(NUM_CS'(1) << spi_cs_sel);
          busy_d    = 1'b1;
          count_d   = count_q + 32'd1;
        end
      end
      ST_SETUP: begin
        // Leading edge of bit 0
        if (lead_c) begin
          state_d = ST_SHIFT;
          phase_d = 1'b0;
          if (mode_q[CPHA_BIT]) begin
            pico_d = wbit_cur_c;
          end else begin
            rmem_we_c = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (trail_c) begin
          // Trailing edge of the current bit
          phase_d = 1'b1;
          if (mode_q[CPHA_BIT]) begin
            rmem_we_c = 1'b1;
          end else if (nxt_idx_c < len_q) begin
            pico_d = wbit_nxt_c;
          end
        end else if (half_c) begin
          // End of the bit: either finish or leading edge of the next bit
          if (last_c) begin
            state_d = ST_HOLD;
          end else begin
            bit_idx_d = nxt_idx_c;
            phase_d   = 1'b0;
            if (mode_q[CPHA_BIT]) begin
              pico_d = wbit_nxt_c;
            end else begin
              rmem_we_c   = 1'b1;
              rmem_word_c = nxt_word_c;
              rmem_bit_c  = nxt_bit_c;
            end
          end
        end
      end
      ST_HOLD: begin
        if (half_c) begin
          state_d = ST_DONE;
          cs_b_d  = '1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    status_d = {busy_d, status_code(state_d)};
  end

  // Memory pointers: reset wins over increment, wrap at MEM_DEPTH-1
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (mem_write_ptr_reset) begin
      wr_ptr_d = '0;
    end else if (mem_write_strb) begin
      wr_ptr_d = (wr_ptr_q == AW'(MEM_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (mem_read_ptr_reset) begin
      rd_ptr_d = '0;
    end else if (mem_read_strb) begin
      rd_ptr_d = (rd_ptr_q == AW'(MEM_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
  end

  // State and output registers
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      mode_q    <= '0;
      div_q     <= '0;
      bit_idx_q <= '0;
      phase_q   <= 1'b0;
      pico_q    <= 1'b0;
      cs_b_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      status_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      phase_q   <= phase_d;
      pico_q    <= pico_d;
      cs_b_q    <= cs_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      count_q   <= count_d;
      status_q  <= status_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Write/read memories; contents survive reset
  always_ff @(posedge axi_clk) begin
    if (mem_write_strb) begin
      wmem[wr_ptr_q] <= mem_write;
    end
    if (rmem_we_c && !axi_reset) begin
      rmem[rmem_word_c][rmem_bit_c] <= rmem_val_c;
    end
  end

  assign pico              = pico_q;
  assign cs_b              = cs_b_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign transaction_count = count_q;
  assign status            = status_q;
  assign mem_write_ptr     = wr_ptr_q;
  assign mem_read_ptr      = rd_ptr_q;
  assign mem_read          = rmem[rd_ptr_q];

endmodule

// File: tb/tb_generic_spi_controller_mc.sv
// Self-checking bench for generic_spi_controller_mc (default configuration).
module tb_generic_spi_controller_mc;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MEM_DEPTH = 64;
  localparam int unsigned NUM_CS    = 4;
  localparam int unsigned CLKDIV_W  = 16;
  localparam int unsigned AW        = 6;
  localparam int unsigned CSW       = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                sclk, pico, poci;
  logic [NUM_CS-1:0]   cs_b;
  logic [DATA_W-1:0]   mem_write;
  logic                mem_write_strb, mem_write_ptr_reset;
  logic [AW-1:0]       mem_write_ptr, mem_read_ptr;
  logic [DATA_W-1:0]   mem_read;
  logic                mem_read_strb, mem_read_ptr_reset;
  logic [31:0]         spi_len;
  logic [CSW-1:0]      spi_cs_sel;
  logic [1:0]          spi_mode;
  logic [CLKDIV_W-1:0] clk_div;
  logic                spi_strb, busy, done;
  logic [31:0]         transaction_count;
  logic [2:0]          status;

  logic tie_lb;
  logic poci_val;
  assign poci = tie_lb ? pico : poci_val;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  logic        exp_bits[$];
  logic        obs_bits[$];
  logic [31:0] exp_words[$];

  always #5 clk = ~clk;

  generic_spi_controller_mc dut (
    .axi_clk             (clk),
    .axi_reset           (rst),
    .sclk                (sclk),
    .pico                (pico),
    .poci                (poci),
    .cs_b                (cs_b),
`ifdef SPI_LOOPBACK_EN
    .loopback            (1'b0),
`endif
    .mem_write           (mem_write),
    .mem_write_strb      (mem_write_strb),
    .mem_write_ptr       (mem_write_ptr),
    .mem_write_ptr_reset (mem_write_ptr_reset),
    .mem_read            (mem_read),
    .mem_read_strb       (mem_read_strb),
    .mem_read_ptr        (mem_read_ptr),
    .mem_read_ptr_reset  (mem_read_ptr_reset),
    .spi_len             (spi_len),
    .spi_cs_sel          (spi_cs_sel),
    .spi_mode            (spi_mode),
    .clk_div             (clk_div),
    .spi_strb            (spi_strb),
    .busy                (busy),
    .done                (done),
    .transaction_count   (transaction_count),
    .status              (status)
  );

  task automatic wr_word(input logic [31:0] d);
    @(negedge clk); mem_write = d; mem_write_strb = 1'b1;
    @(negedge clk); mem_write_strb = 1'b0;
  endtask

  task automatic wr_ptr_clear();
    @(negedge clk); mem_write_ptr_reset = 1'b1;
    @(negedge clk); mem_write_ptr_reset = 1'b0;
  endtask

  task automatic rd_ptr_clear();
    @(negedge clk); mem_read_ptr_reset = 1'b1;
    @(negedge clk); mem_read_ptr_reset = 1'b0;
  endtask

  task automatic rd_step();
    @(negedge clk); mem_read_strb = 1'b1;
    @(negedge clk); mem_read_strb = 1'b0;
  endtask

  // Start one transaction and record what the pins do until a few cycles past done
  task automatic run_txn(input logic [31:0] len, input logic [CSW-1:0] sel,
                         input logic [1:0] mode, input logic [CLKDIV_W-1:0] div,
                         input int budget,
                         output int cs_low, output logic [NUM_CS-1:0] cs_mask,
                         output int done_cnt, output int done_cyc,
                         output logic sclk_first, output logic sclk_bad);
    logic prev_sclk;
    int   cyc;
    int   tail;
    obs_bits.delete();
    @(negedge clk);
    spi_len = len; spi_cs_sel = sel; spi_mode = mode; clk_div = div; spi_strb = 1'b1;
    @(negedge clk);
    spi_strb = 1'b0;
    cs_low = 0; cs_mask = '0; done_cnt = 0; done_cyc = -1;
    sclk_first = sclk; sclk_bad = 1'b0; prev_sclk = sclk;
    cyc = 1; tail = -1;
    while (cyc <= budget && tail != 0) begin
      if (cs_b != '1) begin
        cs_low++;
        cs_mask |= ~cs_b;
      end else if (sclk !== mode[1]) begin
        sclk_bad = 1'b1;
      end
      if (sclk !== prev_sclk && sclk !== mode[1]) obs_bits.push_back(pico);
      prev_sclk = sclk;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          tail = 4;
        end
      end
      if (tail > 0) tail--;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %0b want 0", sclk); end
    checks++; if (pico !== 1'b0) begin errors++; $display("FAIL reset_pico got %0b want 0", pico); end
    checks++; if (cs_b !== 4'hF) begin errors++; $display("FAIL reset_cs_b got %0h want f", cs_b); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %0b%0b want 00", busy, done); end
    checks++; if (mem_write_ptr !== 6'd0 || mem_read_ptr !== 6'd0) begin errors++; $display("FAIL reset_ptrs got %0d/%0d want 0/0", mem_write_ptr, mem_read_ptr); end
    checks++; if (transaction_count !== 32'd0 || status !== 3'd0) begin errors++; $display("FAIL reset_count_status got %0d/%0d want 0/0", transaction_count, status); end
  endtask

  task automatic test_mode0();
    int cs_low, done_cnt, done_cyc, n;
    logic [NUM_CS-1:0] cs_mask;
    logic sf, sb, e, o;
    logic [31:0] w;
    w = 32'h0000_00A5;
    wr_ptr_clear();
    wr_word(w);
    tie_lb = 1'b1;
    for (int i = 0; i < 8; i++) exp_bits.push_back(w[i]);
    exp_words.push_back(32'h0000_00A5);
    exp_count++;
    run_txn(32'd8, 2'd0, 2'd0, 16'd0, 100, cs_low, cs_mask, done_cnt, done_cyc, sf, sb);
    checks++; if (cs_low != 18) begin errors++; $display("FAIL m0_cs_low got %0d want 18", cs_low); end
    checks++; if (cs_mask !== 4'b0001) begin errors++; $display("FAIL m0_cs_mask got %0b want 0001", cs_mask); end
    checks++; if (done_cnt != 1 || done_cyc != 19) begin errors++; $display("FAIL m0_done got cnt %0d cyc %0d want 1/19", done_cnt, done_cyc); end
    checks++; if (transaction_count !== 32'(exp_count)) begin errors++; $display("FAIL m0_count got %0d want %0d", transaction_count, exp_count); end
    checks++; if (sf !== 1'b0 || sb !== 1'b0) begin errors++; $display("FAIL m0_sclk_idle got first %0b bad %0b want 0/0", sf, sb); end
    n = obs_bits.size();
    checks++; if (n != 8) begin errors++; $display("FAIL m0_nbits got %0d want 8", n); end
    while (exp_bits.size() > 0 && obs_bits.size() > 0) begin
      e = exp_bits.pop_front(); o = obs_bits.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL m0_pico_bit got %0b want %0b", o, e); end
    end
    exp_bits.delete();
    rd_ptr_clear();
    w = exp_words.pop_front();
    checks++; if (mem_read[7:0] !== w[7:0]) begin errors++; $display("FAIL m0_read got %0h want %0h", mem_read[7:0], w[7:0]); end
  endtask

  task automatic test_mode3();
    int cs_low, done_cnt, done_cyc, n;
    logic [NUM_CS-1:0] cs_mask;
    logic sf, sb, e, o;
    logic [31:0] w0, w1, r;
    // Prefill read word1 with ones through a mode-0 loopback transfer
    wr_ptr_clear();
    wr_word(32'h1234_5678);
    wr_word(32'hFFFF_FFFF);
    tie_lb = 1'b1;
    exp_count++;
    run_txn(32'd64, 2'd0, 2'd0, 16'd0, 300, cs_low, cs_mask, done_cnt, done_cyc, sf, sb);
    exp_words.push_back(32'hFFFF_FFFF);
    rd_ptr_clear(); rd_step();
    r = exp_words.pop_front();
    checks++; if (mem_read !== r) begin errors++; $display("FAIL m3_prefill got %0h want %0h", mem_read, r); end

    w0 = 32'hDEAD_BEEF; w1 = 32'h0000_00C3;
    wr_ptr_clear();
    wr_word(w0);
    wr_word(w1);
    tie_lb = 1'b0; poci_val = 1'b0;
    for (int i = 0; i < 32; i++) exp_bits.push_back(w0[i]);
    for (int i = 0; i < 8; i++) exp_bits.push_back(w1[i]);
    exp_words.push_back(32'h0000_0000);
    exp_words.push_back(32'hFFFF_FF00);
    exp_count++;
    run_txn(32'd40, 2'd2, 2'd3, 16'd3, 800, cs_low, cs_mask, done_cnt, done_cyc, sf, sb);
    checks++; if (cs_low != 328) begin errors++; $display("FAIL m3_cs_low got %0d want 328", cs_low); end
    checks++; if (cs_mask !== 4'b0100) begin errors++; $display("FAIL m3_cs_mask got %0b want 0100", cs_mask); end
    checks++; if (done_cnt != 1 || done_cyc != 329) begin errors++; $display("FAIL m3_done got cnt %0d cyc %0d want 1/329", done_cnt, done_cyc); end
    checks++; if (sf !== 1'b1 || sb !== 1'b0) begin errors++; $display("FAIL m3_sclk_idle got first %0b bad %0b want 1/0", sf, sb); end
    n = obs_bits.size();
    checks++; if (n != 40) begin errors++; $display("FAIL m3_nbits got %0d want 40", n); end
    while (exp_bits.size() > 0 && obs_bits.size() > 0) begin
      e = exp_bits.pop_front(); o = obs_bits.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL m3_pico_bit got %0b want %0b", o, e); end
    end
    exp_bits.delete();
    rd_ptr_clear();
    r = exp_words.pop_front();
    checks++; if (mem_read !== r) begin errors++; $display("FAIL m3_word0 got %0h want %0h", mem_read, r); end
    rd_step();
    r = exp_words.pop_front();
    checks++; if (mem_read !== r) begin errors++; $display("FAIL m3_word1 got %0h want %0h", mem_read, r); end
    checks++; if (transaction_count !== 32'(exp_count)) begin errors++; $display("FAIL m3_count got %0d want %0d", transaction_count, exp_count); end
  endtask

  task automatic test_ignored();
    logic act;
    int dn;
    // Zero-length strobe
    @(negedge clk); spi_len = 32'd0; spi_strb = 1'b1;
    @(negedge clk); spi_strb = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cs_b !== 4'hF || busy !== 1'b0) act = 1'b1;
      @(negedge clk);
    end
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL ign_len0_activity got %0b want 0", act); end
    checks++; if (transaction_count !== 32'(exp_count)) begin errors++; $display("FAIL ign_len0_count got %0d want %0d", transaction_count, exp_count); end
    // Strobe while busy
    @(negedge clk); spi_len = 32'd4; spi_cs_sel = 2'd1; spi_mode = 2'd0; clk_div = 16'd0; spi_strb = 1'b1;
    exp_count++;
    @(negedge clk); spi_strb = 1'b0;
    repeat (2) @(negedge clk);
    spi_len = 32'd8; spi_strb = 1'b1;
    @(negedge clk); spi_strb = 1'b0;
    dn = 0; act = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dn++;
      if (i > 12 && cs_b !== 4'hF) act = 1'b1;
      @(negedge clk);
    end
    checks++; if (dn != 1) begin errors++; $display("FAIL ign_busy_done got %0d want 1", dn); end
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL ign_busy_activity got %0b want 0", act); end
    checks++; if (transaction_count !== 32'(exp_count)) begin errors++; $display("FAIL ign_busy_count got %0d want %0d", transaction_count, exp_count); end
  endtask

  task automatic test_clamp();
    int cs_low, done_cnt, done_cyc, n;
    logic [NUM_CS-1:0] cs_mask;
    logic sf, sb;
    tie_lb = 1'b1;
    exp_count++;
    run_txn(32'd5000, 2'd1, 2'd0, 16'd0, 4200, cs_low, cs_mask, done_cnt, done_cyc, sf, sb);
    n = obs_bits.size();
    checks++; if (done_cnt != 1 || done_cyc != 4099) begin errors++; $display("FAIL clamp_done got cnt %0d cyc %0d want 1/4099", done_cnt, done_cyc); end
    checks++; if (cs_low != 4098) begin errors++; $display("FAIL clamp_cs_low got %0d want 4098", cs_low); end
    checks++; if (n != 2048) begin errors++; $display("FAIL clamp_nbits got %0d want 2048", n); end
  endtask

  task automatic test_ptr_wrap();
    int cs_low, done_cnt, done_cyc;
    logic [NUM_CS-1:0] cs_mask;
    logic sf, sb;
    logic [31:0] r;
    wr_ptr_clear();
    for (int k = 0; k < 65; k++) wr_word(32'hC000_0000 + 32'(k));
    checks++; if (mem_write_ptr !== 6'd1) begin errors++; $display("FAIL wrap_wptr got %0d want 1", mem_write_ptr); end
    @(negedge clk); mem_write = 32'h5A5A_0001; mem_write_strb = 1'b1; mem_write_ptr_reset = 1'b1;
    @(negedge clk); mem_write_strb = 1'b0; mem_write_ptr_reset = 1'b0;
    checks++; if (mem_write_ptr !== 6'd0) begin errors++; $display("FAIL wrap_same_cycle_ptr got %0d want 0", mem_write_ptr); end
    exp_words.push_back(32'hC000_0040);
    exp_words.push_back(32'h5A5A_0001);
    tie_lb = 1'b1;
    exp_count++;
    run_txn(32'd64, 2'd3, 2'd1, 16'd2, 600, cs_low, cs_mask, done_cnt, done_cyc, sf, sb);
    checks++; if (cs_low != 390 || cs_mask !== 4'b1000) begin errors++; $display("FAIL wrap_m1_cs got %0d/%0b want 390/1000", cs_low, cs_mask); end
    rd_ptr_clear();
    r = exp_words.pop_front();
    checks++; if (mem_read !== r) begin errors++; $display("FAIL wrap_word0 got %0h want %0h", mem_read, r); end
    rd_step();
    r = exp_words.pop_front();
    checks++; if (mem_read !== r) begin errors++; $display("FAIL wrap_word1 got %0h want %0h", mem_read, r); end
    @(negedge clk); mem_read_strb = 1'b1;
    repeat (63) @(negedge clk);
    mem_read_strb = 1'b0;
    checks++; if (mem_read_ptr !== 6'd0) begin errors++; $display("FAIL wrap_rptr got %0d want 0", mem_read_ptr); end
  endtask

  task automatic test_reset_mid();
    int dn;
    logic act;
    @(negedge clk); spi_len = 32'd16; spi_cs_sel = 2'd3; spi_mode = 2'd2; clk_div = 16'd1; spi_strb = 1'b1;
    @(negedge clk); spi_strb = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (busy !== 1'b1 || status !== 3'b101) begin errors++; $display("FAIL mid_active got busy %0b status %0b want 1/101", busy, status); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    checks++; if (cs_b !== 4'hF || sclk !== 1'b0) begin errors++; $display("FAIL mid_pins got cs_b %0h sclk %0b want f/0", cs_b, sclk); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || status !== 3'd0) begin errors++; $display("FAIL mid_flags got %0b%0b/%0d want 00/0", busy, done, status); end
    checks++; if (transaction_count !== 32'(exp_count)) begin errors++; $display("FAIL mid_count got %0d want %0d", transaction_count, exp_count); end
    dn = 0; act = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) dn++;
      if (cs_b !== 4'hF) act = 1'b1;
      @(negedge clk);
    end
    checks++; if (dn != 0 || act !== 1'b0) begin errors++; $display("FAIL mid_after got done %0d act %0b want 0/0", dn, act); end
  endtask

  initial begin
    rst = 1'b1;
    tie_lb = 1'b0; poci_val = 1'b0;
    mem_write = '0; mem_write_strb = 1'b0; mem_write_ptr_reset = 1'b0;
    mem_read_strb = 1'b0; mem_read_ptr_reset = 1'b0;
    spi_len = '0; spi_cs_sel = '0; spi_mode = '0; clk_div = '0; spi_strb = 1'b0;
    test_reset();
    test_mode0();
    test_mode3();
    test_ignored();
    test_clamp();
    test_ptr_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
